// File: rtl/mem_traffic_gen.sv
// Programmable write-then-read traffic generator for memory_controller.
// Replays the write address sequence as reads and checks returned data against an address pattern.
module mem_traffic_gen #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned TIMEOUT   = 256,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [15:0]       num_req,
    output logic [ADDR_W-1:0] wr_address,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] wr_ret_address,
    input  logic              wr_ret_ack,
    output logic [ADDR_W-1:0] rd_address,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_ret_data,
    input  logic [ADDR_W-1:0] rd_ret_address,
    input  logic              rd_ret_ack,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] last_err_addr
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WDRAIN, S_RD, S_RDRAIN, S_DONE} state_t;

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam logic [15:0] SEED = 16'(LFSR_SEED[ADDR_W-1:0]) | 16'h0001;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        logic [ADDR_W+DATA_W-1:0] ext;
        logic [DATA_W-1:0]        mask;
        ext = {{DATA_W{1'b0}}, a};
        for (int unsigned i = 0; i < DATA_W; i++) mask[i] = i[0];
        return ext[DATA_W-1:0] ^ mask;
    endfunction

    state_t            state_q, state_d;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] base_q, stride_q, ofs_q, cur_addr;
    logic [15:0]       num_q, issued_q, lfsr_q, lfsr_next;
    logic [3:0]        outst_q;
    logic [WD_W-1:0]   wdog_q;
    logic              accept, issue, enter_rd, set_timeout, can_issue;
    logic              phase_wr, phase_rd, drain, wd_expire, dec;
    logic              wr_spur, rd_spur, rd_bad;
    logic [1:0]        err_inc;
    logic [16:0]       err_sum;
    logic              unused_ret;

    assign unused_ret = ^wr_ret_address;

    assign phase_wr  = (state_q == S_WR) || (state_q == S_WDRAIN);
    assign phase_rd  = (state_q == S_RD) || (state_q == S_RDRAIN);
    assign drain     = (state_q == S_WDRAIN) || (state_q == S_RDRAIN);
    assign busy      = phase_wr || phase_rd;
    assign done      = (state_q == S_DONE);
    assign can_issue = (issued_q < num_q) && (outst_q < 4'(MAX_OUTST));
    assign wd_expire = drain && !wr_ret_ack && !rd_ret_ack && (wdog_q == WD_W'(TIMEOUT - 1));

    assign cur_addr  = base_q + ((mode_q == 2'd2) ? lfsr_q[ADDR_W-1:0] : ofs_q);
    assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    // Acks only matter during a run; anything arriving in IDLE/DONE is stale.
    assign wr_spur = wr_ret_ack && (phase_rd || (phase_wr && outst_q == '0));
    assign rd_spur = rd_ret_ack && (phase_wr || (phase_rd && outst_q == '0));
    assign rd_bad  = rd_ret_ack && phase_rd && (rd_ret_data != pattern(rd_ret_address));
    assign dec     = (outst_q != '0) && ((phase_wr && wr_ret_ack) || (phase_rd && rd_ret_ack));
    assign err_inc = 2'(wr_spur) + 2'(rd_spur) + 2'(rd_bad);
    assign err_sum = {1'b0, err_count} + 17'(err_inc);

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        issue       = 1'b0;
        enter_rd    = 1'b0;
        set_timeout = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: if (start) begin
                accept  = 1'b1;
                state_d = (num_req == 16'd0) ? S_DONE : S_WR;
            end
            S_WR: begin
                issue = can_issue;
                if (issued_q == num_q) state_d = S_WDRAIN;
            end
            S_WDRAIN: if (outst_q == '0) begin
                state_d  = S_RD;
                enter_rd = 1'b1;
            end else if (wd_expire) begin
                state_d     = S_DONE;
                set_timeout = 1'b1;
            end
            S_RD: begin
                issue = can_issue;
                if (issued_q == num_q) state_d = S_RDRAIN;
            end
            S_RDRAIN: if (outst_q == '0) begin
                state_d = S_DONE;
            end else if (wd_expire) begin
                state_d     = S_DONE;
                set_timeout = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q        <= '0;
            base_q        <= '0;
            stride_q      <= '0;
            num_q         <= '0;
            issued_q      <= '0;
            outst_q       <= '0;
            wdog_q        <= '0;
            ofs_q         <= '0;
            lfsr_q        <= SEED;
            wr_en         <= 1'b0;
            rd_en         <= 1'b0;
            wr_address    <= '0;
            wr_data       <= '0;
            rd_address    <= '0;
            timeout       <= 1'b0;
            err_count     <= '0;
            last_err_addr <= '0;
        end else begin
            wr_en  <= 1'b0;
            rd_en  <= 1'b0;
            wdog_q <= (drain && !wr_ret_ack && !rd_ret_ack) ? wdog_q + 1'b1 : '0;
            if (accept) begin
                mode_q        <= (mode == 2'd3) ? 2'd0 : mode;
                base_q        <= base_addr;
                stride_q      <= stride;
                num_q         <= num_req;
                issued_q      <= '0;
                outst_q       <= '0;
                ofs_q         <= '0;
                lfsr_q        <= SEED;
                timeout       <= 1'b0;
                err_count     <= '0;
                last_err_addr <= '0;
            end else begin
                // Generator restarts on RD entry so reads replay the write sequence.
                if (enter_rd) begin
                    issued_q <= '0;
                    ofs_q    <= '0;
                    lfsr_q   <= SEED;
                end else if (issue) begin
                    issued_q <= issued_q + 16'd1;
                    ofs_q    <= ofs_q + ((mode_q == 2'd1) ? stride_q : ADDR_W'(1));
                    lfsr_q   <= lfsr_next;
                end
                if (issue && phase_wr) begin
                    wr_en      <= 1'b1;
                    wr_address <= cur_addr;
                    wr_data    <= pattern(cur_addr);
                end
                if (issue && phase_rd) begin
                    rd_en      <= 1'b1;
                    rd_address <= cur_addr;
                end
                if (busy) begin
                    if (issue && !dec)      outst_q <= outst_q + 4'd1;
                    else if (!issue && dec) outst_q <= outst_q - 4'd1;
                end
                if (err_inc != 2'd0)
                    err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
                if (rd_bad) last_err_addr <= rd_ret_address;
                if (set_timeout) timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_traffic_gen.sv
// Scoreboard bench for mem_traffic_gen: a latency-configurable memory model answers requests,
// expected address/data sequences are queued at start and popped as wr_en/rd_en appear.
module tb_mem_traffic_gen;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MO = 4;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = '0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] stride = '0;
    logic [15:0]   num_req = '0;
    logic [AW-1:0] wr_address;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] wr_ret_address = '0;
    logic          wr_ret_ack = 1'b0;
    logic [AW-1:0] rd_address;
    logic          rd_en;
    logic [DW-1:0] rd_ret_data = '0;
    logic [AW-1:0] rd_ret_address = '0;
    logic          rd_ret_ack = 1'b0;
    logic          busy, done, timeout;
    logic [15:0]   err_count;
    logic [AW-1:0] last_err_addr;

    always #5 clk = ~clk;

    mem_traffic_gen #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO), .TIMEOUT(TO), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base_addr(base_addr),
        .stride(stride), .num_req(num_req), .wr_address(wr_address), .wr_en(wr_en),
        .wr_data(wr_data), .wr_ret_address(wr_ret_address), .wr_ret_ack(wr_ret_ack),
        .rd_address(rd_address), .rd_en(rd_en), .rd_ret_data(rd_ret_data),
        .rd_ret_address(rd_ret_address), .rd_ret_ack(rd_ret_ack), .busy(busy), .done(done),
        .timeout(timeout), .err_count(err_count), .last_err_addr(last_err_addr)
    );

    typedef struct {
        int          due;
        logic [15:0] addr;
    } req_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    req_t        wq[$];
    req_t        rq[$];
    logic [15:0] exp_wr[$];
    logic [15:0] exp_rd[$];
    logic [15:0] mem[logic [15:0]];
    int lat = 1;
    int corrupt = -1;
    bit drop_rd = 1'b0;
    int wr_seen, rd_seen, out_wr, out_rd, max_wr, max_rd, last_rd_cyc;

    task automatic clear_stats;
        wr_seen = 0; rd_seen = 0; out_wr = 0; out_rd = 0; max_wr = 0; max_rd = 0;
    endtask

    // One cycle: observe requests at negedge, score them, then drive due responses.
    task automatic step;
        logic [15:0] e;
        req_t r;
        @(negedge clk);
        cyc++;
        if (wr_en === 1'b1) begin
            wr_seen++;
            total++;
            if (exp_wr.size() == 0) begin
                bad++;
                $display("FAIL wr_extra: addr=%h but no write expected", wr_address);
            end else begin
                e = exp_wr.pop_front();
                if (wr_address !== e || wr_data !== (e ^ 16'hAAAA)) begin
                    bad++;
                    $display("FAIL wr_req: addr=%h data=%h expected addr=%h data=%h",
                             wr_address, wr_data, e, e ^ 16'hAAAA);
                end
            end
            mem[wr_address] = wr_data;
            r.due = cyc + lat; r.addr = wr_address;
            wq.push_back(r);
            out_wr++;
            if (out_wr > max_wr) max_wr = out_wr;
        end
        if (rd_en === 1'b1) begin
            rd_seen++;
            total++;
            last_rd_cyc = cyc;
            if (exp_rd.size() == 0) begin
                bad++;
                $display("FAIL rd_extra: addr=%h but no read expected", rd_address);
            end else begin
                e = exp_rd.pop_front();
                if (rd_address !== e) begin
                    bad++;
                    $display("FAIL rd_req: addr=%h expected %h", rd_address, e);
                end
            end
            r.due = cyc + lat; r.addr = rd_address;
            rq.push_back(r);
            out_rd++;
            if (out_rd > max_rd) max_rd = out_rd;
        end
        wr_ret_ack = 1'b0;
        if (wq.size() > 0 && wq[0].due <= cyc) begin
            r = wq.pop_front();
            wr_ret_ack = 1'b1;
            wr_ret_address = r.addr;
            out_wr--;
        end
        rd_ret_ack = 1'b0;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            r = rq.pop_front();
            out_rd--;
            if (!drop_rd) begin
                rd_ret_ack = 1'b1;
                rd_ret_address = r.addr;
                rd_ret_data = mem.exists(r.addr) ? mem[r.addr] : 16'h0000;
                if (int'(r.addr) == corrupt) rd_ret_data = rd_ret_data ^ 16'h0001;
            end
        end
    endtask

    task automatic push_expected(input logic [1:0] m, input logic [15:0] b, input logic [15:0] s,
                                 input int n);
        logic [15:0] l, a;
        l = 16'hACE1 | 16'h0001;
        for (int k = 0; k < n; k++) begin
            case (m)
                2'd1:    a = 16'(int'(b) + k * int'(s));
                2'd2:    a = b + l;
                default: a = 16'(int'(b) + k);
            endcase
            exp_wr.push_back(a);
            exp_rd.push_back(a);
            l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
        end
    endtask

    task automatic start_run(input logic [1:0] m, input logic [15:0] b, input logic [15:0] s,
                             input int n);
        clear_stats();
        mode = m; base_addr = b; stride = s; num_req = 16'(n);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        int i;
        i = 0;
        while (done !== 1'b1 && i < budget) begin
            step();
            i++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL done_wait: done=%b after %0d cycles, required 1", done, budget);
        end
    endtask

    task automatic test_reset;
        step(); step();
        total++;
        if ({wr_en, rd_en, busy, done, timeout} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: {wr_en,rd_en,busy,done,timeout}=%b required 00000",
                     {wr_en, rd_en, busy, done, timeout});
        end
        total++;
        if (err_count !== 16'h0 || last_err_addr !== 16'h0) begin
            bad++;
            $display("FAIL reset_err: err_count=%h last_err_addr=%h required 0/0",
                     err_count, last_err_addr);
        end
        total++;
        if (wr_address !== 16'h0 || wr_data !== 16'h0 || rd_address !== 16'h0) begin
            bad++;
            $display("FAIL reset_bus: wr_address=%h wr_data=%h rd_address=%h required 0",
                     wr_address, wr_data, rd_address);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_zero_req;
        start_run(2'd0, 16'h0010, 16'h0, 0);
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_req_done: done=%b busy=%b required 1/0", done, busy);
        end
        repeat (3) step();
        total++;
        if (wr_seen + rd_seen != 0) begin
            bad++;
            $display("FAIL zero_req_en: %0d requests seen, required 0", wr_seen + rd_seen);
        end
    endtask

    task automatic test_seq;
        lat = 1;
        push_expected(2'd0, 16'h0000, 16'h0, 8);
        start_run(2'd0, 16'h0000, 16'h0, 8);
        repeat (3) step();
        mode = 2'd1; base_addr = 16'h0040; num_req = 16'd3; start = 1'b1;
        step();
        start = 1'b0;
        run_until_done(200);
        total++;
        if (wr_seen != 8 || rd_seen != 8) begin
            bad++;
            $display("FAIL seq_count: wr=%0d rd=%0d required 8/8", wr_seen, rd_seen);
        end
        total++;
        if (err_count !== 16'h0 || timeout !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL seq_status: err=%h timeout=%b busy=%b required 0/0/0",
                     err_count, timeout, busy);
        end
    endtask

    task automatic test_stride_wrap;
        lat = 1;
        exp_wr.push_back(16'hFFFE); exp_wr.push_back(16'h0001);
        exp_wr.push_back(16'h0004); exp_wr.push_back(16'h0007);
        exp_rd.push_back(16'hFFFE); exp_rd.push_back(16'h0001);
        exp_rd.push_back(16'h0004); exp_rd.push_back(16'h0007);
        start_run(2'd1, 16'hFFFE, 16'd3, 4);
        run_until_done(200);
        total++;
        if (wr_seen != 4 || rd_seen != 4 || err_count !== 16'h0) begin
            bad++;
            $display("FAIL stride_wrap: wr=%0d rd=%0d err=%h required 4/4/0",
                     wr_seen, rd_seen, err_count);
        end
    endtask

    task automatic test_latency_lfsr;
        lat = 10;
        push_expected(2'd2, 16'h0100, 16'h0, 8);
        start_run(2'd2, 16'h0100, 16'h0, 8);
        run_until_done(400);
        total++;
        if (max_wr != MO || max_rd != MO) begin
            bad++;
            $display("FAIL outst_limit: max_wr=%0d max_rd=%0d required %0d", max_wr, max_rd, MO);
        end
        total++;
        if (wr_seen != 8 || rd_seen != 8 || err_count !== 16'h0) begin
            bad++;
            $display("FAIL latency_run: wr=%0d rd=%0d err=%h required 8/8/0",
                     wr_seen, rd_seen, err_count);
        end
        lat = 1;
    endtask

    task automatic test_corrupt;
        corrupt = 5;
        push_expected(2'd0, 16'h0000, 16'h0, 8);
        start_run(2'd0, 16'h0000, 16'h0, 8);
        run_until_done(200);
        total++;
        if (err_count !== 16'd1 || last_err_addr !== 16'h0005) begin
            bad++;
            $display("FAIL corrupt: err=%h last_err_addr=%h required 0001/0005",
                     err_count, last_err_addr);
        end
        corrupt = -1;
    endtask

    task automatic test_timeout;
        drop_rd = 1'b1;
        push_expected(2'd0, 16'h0020, 16'h0, 4);
        start_run(2'd0, 16'h0020, 16'h0, 4);
        run_until_done(300);
        total++;
        if (timeout !== 1'b1 || done !== 1'b1) begin
            bad++;
            $display("FAIL timeout_flag: timeout=%b done=%b required 1/1", timeout, done);
        end
        total++;
        if (cyc - last_rd_cyc != TO + 1) begin
            bad++;
            $display("FAIL timeout_delay: done %0d cycles after last rd_en, required %0d",
                     cyc - last_rd_cyc, TO + 1);
        end
        drop_rd = 1'b0;
    endtask

    task automatic test_mid_reset;
        int i;
        push_expected(2'd0, 16'h0300, 16'h0, 8);
        start_run(2'd0, 16'h0300, 16'h0, 8);
        i = 0;
        while (rd_seen == 0 && i < 100) begin
            step();
            i++;
        end
        total++;
        if (rd_seen == 0) begin
            bad++;
            $display("FAIL mid_reset_reach_rd: rd_en=%b never seen, required 1", rd_en);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({wr_en, rd_en, busy, done, timeout} !== 5'b0 || err_count !== 16'h0 ||
            wr_address !== 16'h0 || rd_address !== 16'h0 || wr_data !== 16'h0) begin
            bad++;
            $display("FAIL mid_reset_out: flags=%b err=%h wa=%h ra=%h wd=%h required all 0",
                     {wr_en, rd_en, busy, done, timeout}, err_count, wr_address, rd_address,
                     wr_data);
        end
        step(); step();
        rst_n = 1'b1;
        exp_wr.delete();
        exp_rd.delete();
        repeat (4) step();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || err_count !== 16'h0) begin
            bad++;
            $display("FAIL idle_stale_ack: busy=%b done=%b err=%h required 0/0/0",
                     busy, done, err_count);
        end
        push_expected(2'd2, 16'h1234, 16'h0, 6);
        start_run(2'd2, 16'h1234, 16'h0, 6);
        run_until_done(200);
        total++;
        if (wr_seen != 6 || rd_seen != 6 || err_count !== 16'h0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL clean_rerun: wr=%0d rd=%0d err=%h timeout=%b required 6/6/0/0",
                     wr_seen, rd_seen, err_count, timeout);
        end
    endtask

    initial begin
        clear_stats();
        last_rd_cyc = 0;
        test_reset();
        test_zero_req();
        test_seq();
        test_stride_wrap();
        test_latency_lfsr();
        test_corrupt();
        test_timeout();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
